rv32i_ci_issue_queue: RTL and testbench

- Upstream stage between the RV32I core's custom-instruction (CI) port and the image-memory CI wrapper (opcode 0x33, funct7 0x06).
- Filters and buffers CIs in an in-order FIFO and presents them to the wrapper with valid/ready.
- Routes the wrapper's rd writebacks back to the core, registered.
- Keeps a 32-bit scoreboard of rd registers awaiting writeback so the core can interlock.

---
 rtl/rv32i_ci_pkg.sv | 25 ++
 rtl/ci_sync_fifo.sv | 52 +++++
 rtl/rv32i_ci_issue_queue.sv | 161 ++++++++++++++++
 tb/tb_rv32i_ci_issue_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ci_pkg.sv
// Shared definitions for the RV32I custom-instruction issue path:
// opcode/funct constants, the queued entry layout and the op-class helper.
package rv32i_ci_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'h33;
  localparam logic [6:0] F7_IMG     = 7'h06;

  localparam logic [2:0] F3_IM_WR   = 3'b000;
  localparam logic [2:0] F3_IM_RD   = 3'b001;
  localparam logic [2:0] F3_IM_STAT = 3'b010;

  // One queued CI: the raw instruction, its operands and destination register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } ci_entry_t;

  // RD and STAT produce a value for rd; WR does not.
  function automatic logic is_returning(input logic [2:0] f3);
    return (f3 == F3_IM_RD) || (f3 == F3_IM_STAT);
  endfunction

endpackage

// File: rtl/ci_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is read combinationally from
// storage; pointers carry one extra wrap bit so full and empty differ.
// DEPTH must be a power of two, >= 2. Push while full / pop while empty
// are ignored.
module ci_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 101
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Advance read/write pointers; they wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/rv32i_ci_issue_queue.sv
// Issue queue between the core's custom-instruction port and the image
// CI wrapper: decode/filter, in-order buffering, rd scoreboard for the
// core's interlock, and registered writeback routing.
// Optional: define CI_PERF_EN to build saturating issue/stall counters;
// otherwise perf_issued/perf_stall read as zero.
module rv32i_ci_issue_queue
  import rv32i_ci_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_valid,
  output logic                    core_ready,
  input  logic [31:0]             core_instr,
  input  logic [31:0]             core_rs1,
  input  logic [31:0]             core_rs2,
  input  logic [4:0]              core_rd,
  output logic                    core_illegal,
  output logic                    core_wb_we,
  output logic [4:0]              core_wb_addr,
  output logic [31:0]             core_wb_data,
  output logic [31:0]             rd_pending,
  output logic                    ci_valid,
  input  logic                    ci_ready,
  output logic [31:0]             ci_instr,
  output logic [31:0]             ci_rs1,
  output logic [31:0]             ci_rs2,
  output logic [4:0]              ci_rd,
  input  logic                    ci_rd_we,
  input  logic [4:0]              ci_rd_waddr,
  input  logic [31:0]             ci_rd_wdata,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [CNT_W-1:0]        perf_issued,
  output logic [CNT_W-1:0]        perf_stall
);

  logic [2:0]   w_f3;
  logic         w_legal;
  logic         w_returning;
  logic         w_waw;
  logic         w_full;
  logic         w_empty;
  logic         w_accept;
  logic         w_push;
  logic         w_pop;
  logic [31:0]  w_set_mask;
  logic [31:0]  w_clr_mask;
  ci_entry_t    w_wentry;
  ci_entry_t    w_head;

  logic [31:0]  r_pending;
  logic         r_illegal;
  logic         r_wb_we;
  logic [4:0]   r_wb_addr;
  logic [31:0]  r_wb_data;

  // Decode: only the image CI group with a known funct3 is legal.
  assign w_f3        = core_instr[14:12];
  assign w_legal     = (core_instr[6:0] == OPC_RTYPE) && (core_instr[31:25] == F7_IMG) &&
                       ((w_f3 == F3_IM_WR) || (w_f3 == F3_IM_RD) || (w_f3 == F3_IM_STAT));
  assign w_returning = is_returning(w_f3);

  // WAW interlock: a returning op may not target an rd still awaiting writeback.
  assign w_waw       = w_returning && (core_rd != 5'd0) && r_pending[core_rd];

  // Illegal CIs are always swallowed so the core can trap on them.
  assign core_ready  = w_legal ? (!w_full && !w_waw) : 1'b1;
  assign w_accept    = core_valid && core_ready;
  assign w_push      = w_accept && w_legal;
  assign w_pop       = !w_empty && ci_ready;

  assign w_wentry = '{instr: core_instr, rs1: core_rs1, rs2: core_rs2, rd: core_rd};

  ci_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ci_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign ci_valid = !w_empty;
  assign ci_instr = w_head.instr;
  assign ci_rs1   = w_head.rs1;
  assign ci_rs2   = w_head.rs2;
  assign ci_rd    = w_head.rd;

  assign w_set_mask = (w_push && w_returning && (core_rd != 5'd0)) ? (32'd1 << core_rd) : 32'd0;
  assign w_clr_mask = ci_rd_we ? (32'd1 << ci_rd_waddr) : 32'd0;

  // Scoreboard: clear on writeback, then set on push (set wins); x0 never pends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end
  end

  assign rd_pending = r_pending;

  // One-cycle illegal pulse and registered writeback toward the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      r_wb_we   <= ci_rd_we && (ci_rd_waddr != 5'd0);
      r_wb_addr <= ci_rd_waddr;
      r_wb_data <= ci_rd_wdata;
    end
  end

  assign core_illegal = r_illegal;
  assign core_wb_we   = r_wb_we;
  assign core_wb_addr = r_wb_addr;
  assign core_wb_data = r_wb_data;

`ifdef CI_PERF_EN
  logic [CNT_W-1:0] r_perf_issued;
  logic [CNT_W-1:0] r_perf_stall;

  // Saturating counters of pops and of stalled core offers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_pop && (r_perf_issued != {CNT_W{1'b1}}))
        r_perf_issued <= r_perf_issued + 1'b1;
      if (core_valid && !core_ready && (r_perf_stall != {CNT_W{1'b1}}))
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif

`ifndef SYNTHESIS
  // The interlock should make a same-cycle set and clear of one bit impossible.
  a_set_clr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    (w_set_mask & w_clr_mask) == 32'd0);
`endif

endmodule

// File: tb/tb_rv32i_ci_issue_queue.sv
// Randomised + directed bench for rv32i_ci_issue_queue against a queue-based
// reference model. Honours CI_PERF_EN for the perf counter expectations.
module tb_rv32i_ci_issue_queue;
  import rv32i_ci_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef CI_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_valid = 1'b0, core_ready, core_illegal, core_wb_we;
  logic [31:0] core_instr = '0, core_rs1 = '0, core_rs2 = '0, core_wb_data, rd_pending;
  logic [4:0] core_rd = '0, core_wb_addr, ci_rd, ci_rd_waddr = '0;
  logic ci_valid, ci_ready = 1'b0, ci_rd_we = 1'b0;
  logic [31:0] ci_instr, ci_rs1, ci_rs2, ci_rd_wdata = '0;
  logic [CW-1:0] fifo_count;
  logic [CNT_W-1:0] perf_issued, perf_stall;

  always #5 clk = ~clk;

  rv32i_ci_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_valid(core_valid), .core_ready(core_ready), .core_instr(core_instr),
    .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd(core_rd),
    .core_illegal(core_illegal), .core_wb_we(core_wb_we), .core_wb_addr(core_wb_addr),
    .core_wb_data(core_wb_data), .rd_pending(rd_pending),
    .ci_valid(ci_valid), .ci_ready(ci_ready), .ci_instr(ci_instr), .ci_rs1(ci_rs1),
    .ci_rs2(ci_rs2), .ci_rd(ci_rd), .ci_rd_we(ci_rd_we), .ci_rd_waddr(ci_rd_waddr),
    .ci_rd_wdata(ci_rd_wdata), .fifo_count(fifo_count),
    .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  ci_entry_t   q[$];
  logic [31:0] m_pend = '0;
  logic        m_ill = 1'b0, m_wb_we = 1'b0;
  logic [4:0]  m_wb_addr = '0;
  logic [31:0] m_wb_data = '0;
  int          m_issued = 0, m_stall = 0;
  int          owed[$];

  function automatic logic m_legal(input logic [31:0] ins);
    return ins[6:0] == 7'h33 && ins[31:25] == 7'h06 && ins[14:12] <= 3'd2;
  endfunction

  function automatic logic m_ret(input logic [31:0] ins);
    return ins[14:12] == 3'd1 || ins[14:12] == 3'd2;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  task automatic model_reset();
    q.delete(); owed.delete();
    m_pend = '0; m_ill = 0; m_wb_we = 0; m_wb_addr = '0; m_wb_data = '0;
    m_issued = 0; m_stall = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] rd,
                       input logic [31:0] r1, input logic crdy);
    core_valid = v; core_instr = ins; core_rd = rd; core_rs1 = r1; core_rs2 = ~r1;
    ci_ready = crdy; ci_rd_we = 1'b0; ci_rd_waddr = '0; ci_rd_wdata = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    ci_rd_we = 1'b1; ci_rd_waddr = a; ci_rd_wdata = d;
  endtask

  // Called at posedge+1 with inputs driven: check outputs late in the cycle,
  // advance the model by what the coming edge does, then move past the edge.
  task automatic cycle();
    logic lg, rt, rdy, acc, pop;
    ci_entry_t h;
    #3;
    lg  = m_legal(core_instr);
    rt  = m_ret(core_instr);
    rdy = lg ? (q.size() < DEPTH && !(rt && core_rd != 0 && m_pend[core_rd])) : 1'b1;
    check("core_ready", core_ready, rdy);
    check("ci_valid", ci_valid, q.size() != 0);
    check("fifo_count", fifo_count, q.size());
    check("rd_pending", rd_pending, m_pend);
    check("core_illegal", core_illegal, m_ill);
    check("core_wb_we", core_wb_we, m_wb_we);
    if (m_wb_we) begin
      check("core_wb_addr", core_wb_addr, m_wb_addr);
      check("core_wb_data", core_wb_data, m_wb_data);
    end
    if (q.size() != 0) begin
      h = q[0];
      check("ci_instr", ci_instr, h.instr);
      check("ci_rs1", ci_rs1, h.rs1);
      check("ci_rs2", ci_rs2, h.rs2);
      check("ci_rd", ci_rd, h.rd);
    end
    check("perf_issued", perf_issued, PERF ? m_issued : 0);
    check("perf_stall", perf_stall, PERF ? m_stall : 0);

    acc = core_valid && rdy;
    pop = q.size() != 0 && ci_ready;
    if (pop) begin
      h = q.pop_front();
      if (m_ret(h.instr) && h.rd != 0) owed.push_back(h.rd);
      if (m_issued < (1 << CNT_W) - 1) m_issued++;
      $display("pop  instr=%08h rs1=%08h rd=%0d", h.instr, h.rs1, h.rd);
    end
    if (ci_rd_we) begin
      m_pend[ci_rd_waddr] = 1'b0;
      for (int i = owed.size() - 1; i >= 0; i--)
        if (owed[i] == ci_rd_waddr) owed.delete(i);
    end
    if (acc && lg) begin
      q.push_back('{instr: core_instr, rs1: core_rs1, rs2: core_rs2, rd: core_rd});
      if (rt && core_rd != 0) m_pend[core_rd] = 1'b1;
      $display("push instr=%08h rs1=%08h rd=%0d", core_instr, core_rs1, core_rd);
    end
    if (acc && !lg) $display("illegal instr=%08h consumed", core_instr);
    if (core_valid && !rdy && m_stall < (1 << CNT_W) - 1) m_stall++;
    m_pend[0] = 1'b0;
    m_wb_we   = ci_rd_we && ci_rd_waddr != 0;
    m_wb_addr = ci_rd_waddr;
    m_wb_data = ci_rd_wdata;
    m_ill     = acc && !lg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rs_tab [4];
    rs_tab[0] = 32'h0000_0000; rs_tab[1] = 32'h0000_0001;
    rs_tab[2] = 32'h0002_0003; rs_tab[3] = 32'h0007_0007;

    // Reset
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, '0, 0, '0, 0); cycle();

    // Fill with 4 WR CIs while the wrapper stalls, then one refused offer
    for (int i = 0; i < 4; i++) begin drive(1, mk(7'h06, 3'd0, 5'd9), 5'd9, rs_tab[i], 0); cycle(); end
    drive(1, mk(7'h06, 3'd0, 5'd9), 5'd9, 32'h55, 0); cycle(); cycle();
    for (int i = 0; i < 5; i++) begin drive(0, '0, 0, '0, 1); cycle(); end

    // RD x7, then a second RD x7 held by the interlock until writeback
    drive(1, mk(7'h06, 3'd1, 5'd7), 5'd7, 32'h71, 1); cycle();
    drive(0, '0, 0, '0, 1); cycle();
    for (int i = 0; i < 3; i++) begin drive(1, mk(7'h06, 3'd1, 5'd7), 5'd7, 32'h72, 1); cycle(); end
    drive(1, mk(7'h06, 3'd1, 5'd7), 5'd7, 32'h72, 1); wb(5'd7, 32'h3f80_0000); cycle();
    drive(1, mk(7'h06, 3'd1, 5'd7), 5'd7, 32'h72, 1); cycle();
    drive(0, '0, 0, '0, 1); cycle();
    drive(0, '0, 0, '0, 1); wb(5'd7, 32'h1234_5678); cycle();

    // Illegal CIs accepted while full
    for (int i = 0; i < 4; i++) begin drive(1, mk(7'h06, 3'd0, 5'd1), 5'd1, 32'h100 + i, 0); cycle(); end
    drive(1, mk(7'h00, 3'd1, 5'd4), 5'd4, 32'h200, 0); cycle();
    drive(1, mk(7'h06, 3'd3, 5'd4), 5'd4, 32'h201, 0); cycle();
    drive(0, '0, 0, '0, 0); cycle();
    for (int i = 0; i < 4; i++) begin drive(0, '0, 0, '0, 1); cycle(); end

    // STAT to x0, writeback to x0 dropped, non-pending writeback forwarded
    drive(1, mk(7'h06, 3'd2, 5'd0), 5'd0, 32'h300, 1); cycle();
    drive(0, '0, 0, '0, 1); cycle();
    drive(0, '0, 0, '0, 0); wb(5'd0, 32'hdead_beef); cycle();
    drive(0, '0, 0, '0, 0); wb(5'd5, 32'hcafe_f00d); cycle();
    drive(0, '0, 0, '0, 0); cycle();

    // Steady push+pop at occupancy 2; pointers wrap several times
    for (int i = 0; i < 2; i++) begin drive(1, mk(7'h06, 3'd0, 5'd2), 5'd2, 32'h400 + i, 0); cycle(); end
    for (int i = 0; i < 10; i++) begin drive(1, mk(7'h06, 3'd0, 5'd2), 5'd2, 32'h500 + i, 1); cycle(); end
    for (int i = 0; i < 3; i++) begin drive(0, '0, 0, '0, 1); cycle(); end

    // Randomised traffic with a wrapper that eventually answers returning ops
    for (int n = 0; n < 1500; n++) begin
      int kind;
      logic [31:0] ins;
      logic [4:0] rd;
      kind = $urandom_range(0, 9);
      rd   = 5'($urandom_range(0, 7));
      if (kind < 7)       ins = mk(7'h06, 3'($urandom_range(0, 2)), rd);
      else if (kind == 7) ins = mk(7'($urandom_range(0, 5)), 3'd1, rd);
      else if (kind == 8) ins = mk(7'h06, 3'($urandom_range(3, 7)), rd);
      else                ins = {mk(7'h06, 3'd1, rd)} ^ 32'h0000_0004;
      drive($urandom_range(0, 3) != 0, ins, rd, $urandom, $urandom_range(0, 2) != 0);
      if (owed.size() != 0 && $urandom_range(0, 2) == 0)
        wb(5'(owed[$urandom_range(0, owed.size() - 1)]), $urandom);
      else if ($urandom_range(0, 19) == 0)
        wb(5'd0, $urandom);
      cycle();
    end
    for (int i = 0; i < 6; i++) begin drive(0, '0, 0, '0, 1); cycle(); end

    // Asynchronous reset with 3 queued and x3 pending
    drive(1, mk(7'h06, 3'd1, 5'd3), 5'd3, 32'h600, 0); cycle();
    drive(1, mk(7'h06, 3'd0, 5'd4), 5'd4, 32'h601, 0); cycle();
    drive(1, mk(7'h06, 3'd0, 5'd4), 5'd4, 32'h602, 0); cycle();
    drive(0, '0, 0, '0, 0);
    check("pre_reset_count", fifo_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_ci_valid", ci_valid, 0);
    check("async_rd_pending", rd_pending, 0);
    check("async_fifo_count", fifo_count, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
